dmem_responder: RTL



---
 rtl/lc3b_types.sv | 15 +
 rtl/mem_wmask_merge.sv | 18 +
 rtl/dmem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types; data-port memory state and byte-mask types
// are used by the data memory responder and the write-mask merge logic.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef logic [1:0] lc3b_mem_mask;

   typedef enum logic [1:0] {
      mem_idle,
      mem_wait,
      mem_resp
   } lc3b_mem_state;

endpackage : lc3b_types

// File: rtl/mem_wmask_merge.sv
// Byte-granular merge of a new word into an old word under a 2-bit byte mask.
// Purely combinational so it can sit on any storage commit path.
module mem_wmask_merge
   import lc3b_types::*;
(
   input  logic [15:0] old_word_i,
   input  logic [15:0] new_word_i,
   input  logic [1:0]  mask_i,
   output logic [15:0] merged_o
);

   always_comb begin
      merged_o       = old_word_i;
      if (mask_i[0]) merged_o[7:0]  = new_word_i[7:0];
      if (mask_i[1]) merged_o[15:8] = new_word_i[15:8];
   end

endmodule : mem_wmask_merge

// File: rtl/dmem_responder.sv
// Flop-based data memory answering the MEM-stage data-port protocol with a
// programmable response latency and byte-masked writes.
module dmem_responder
   import lc3b_types::*;
#(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_b,
   input  logic        write_b,
   input  logic [1:0]  wmask_b,
   input  logic [15:0] address_b,
   input  logic [15:0] wdata_b,
   output logic        resp_b,
   output logic [15:0] rdata_b
);

   localparam int unsigned    DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0]     CNT_INIT = 4'(LATENCY - 1);

   lc3b_mem_state             state_q, state_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]     idx_q, idx_d;
   lc3b_word                  wdata_q, wdata_d;
   lc3b_mem_mask              wmask_q, wmask_d;
   logic                      is_wr_q, is_wr_d;
   logic                      resp_q, resp_d;
   lc3b_word                  rdata_q, rdata_d;
   lc3b_word                  mem_q [DEPTH];

   logic                      req;
   logic                      commit;
   logic [DEPTH_LOG2-1:0]     addr_idx;
   lc3b_word                  merged;
   logic                      unused_addr_bits;

   assign req              = read_b | write_b;
   assign addr_idx         = address_b[DEPTH_LOG2:1];
   assign unused_addr_bits = ^{address_b[15:DEPTH_LOG2+1], address_b[0]};

   // rdata is captured on the edge entering RESP, before the commit on the
   // edge leaving RESP, so a write response returns the pre-write word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      is_wr_d = is_wr_q;
      resp_d  = 1'b0;
      rdata_d = rdata_q;
      commit  = 1'b0;
      unique case (state_q)
         mem_idle: begin
            if (req) begin
               idx_d   = addr_idx;
               wdata_d = wdata_b;
               wmask_d = wmask_b;
               is_wr_d = write_b;
               cnt_d   = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d = mem_resp;
                  resp_d  = 1'b1;
                  rdata_d = mem_q[addr_idx];
               end else begin
                  state_d = mem_wait;
               end
            end
         end
         mem_wait: begin
            if (!req) begin
               state_d = mem_idle;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = mem_resp;
                  resp_d  = 1'b1;
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         mem_resp: begin
            state_d = mem_idle;
            commit  = is_wr_q;
         end
         default: state_d = mem_idle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= mem_idle;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         is_wr_q <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         is_wr_q <= is_wr_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
      end
   end

   mem_wmask_merge u_merge (
      .old_word_i (mem_q[idx_q]),
      .new_word_i (wdata_q),
      .mask_i     (wmask_q),
      .merged_o   (merged)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         mem_q[idx_q] <= merged;
      end
   end

   assign resp_b  = resp_q;
   assign rdata_b = rdata_q;

endmodule : dmem_responder
